coax_bus_sched: RTL and testbench
=================================

// Module: coax_bus_sched
// PURPOSE
//  Sequences the shared 10-bit coax data bus between the transmit path (tx_load/tx_full) and the receive path (rx_read/rx_data_available).
//  Host words arrive on valid/ready; the block drives the bus and strobes tx_load.
//  Received words are drained with rx_enable/rx_read into a one-entry host output register.
//  Enforces bus turnaround, settle/strobe widths sized for the 2-flop input synchronizers, and bounded-fairness TX/RX arbitration.
// PARAMETERS
//  SETTLE_CYCLES   2  bus stable before strobe (TX) / rx_enable before capture (RX)
//  STROBE_CYCLES   3  tx_load/rx_read high width; >=3 covers 2-flop sync + sample
//  RECOVER_CYCLES  4  post-strobe wait so tx_full/rx_data_available reflect the strobe
//  TURN_CYCLES     2  bus fully released (bus_oe=0, rx_enable=0) on driver change
//  MAX_RX_BURST    4  consecutive RX grants before a pending TX wins
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high
//  host_tx_data      in   10  word to transmit
//  host_tx_valid     in   1   host word pending
//  host_tx_ready     out  1   1-cycle accept pulse at TX grant
//  host_rx_data      out  10  received word
//  host_rx_error     out  1   rx_error sampled with word
//  host_rx_valid     out  1   host output register full
//  host_rx_ready     in   1   host consumes word
//  bus_out           out  10  word driven onto shared bus
//  bus_oe            out  1   drive enable for bus_out
//  bus_in            in   10  shared bus read-back
//  rx_enable         out  1   receiver drives bus
//  tx_load           out  1   transmit load strobe
//  tx_full           in   1   transmitter cannot accept
//  rx_active         in   1   inbound frame on line
//  rx_error          in   1   receiver error flag
//  rx_data_available in   1   receiver holds a word
//  rx_read           out  1   receive read strobe
//  rx_err_count      out  8   error count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, last_driver=NONE, burst=0, timers 0, bus_out=0.
//  Invariant: bus_oe & rx_enable never both 1.
//  States: IDLE, TURN, TX_SETUP, TX_STROBE, TX_RECOVER, RX_SETUP, RX_STROBE, RX_RECOVER.
//  IDLE arbitration (evaluated every IDLE cycle):
//   rx_cand = rx_data_available & ~host_rx_valid
//   tx_cand = host_tx_valid & ~tx_full & ~rx_active
//   Both pending: RX wins unless burst==MAX_RX_BURST.
//   RX grant: burst+1 (saturates). TX grant: burst=0. No rx_cand: burst=0.
//   Grant to a driver != last_driver (NONE counts as different): TURN for TURN_CYCLES, both enables 0, then SETUP. Otherwise straight to SETUP.
//  TX:
//   At grant: host_tx_ready=1 for one cycle; bus_out<=host_tx_data.
//   TX_SETUP: bus_oe=1 for SETTLE_CYCLES. TX_STROBE: tx_load=1 for STROBE_CYCLES.
//   TX_RECOVER: RECOVER_CYCLES with bus held, then IDLE.
//   bus_oe stays 1 in IDLE while last_driver=TX.
//  RX:
//   RX_SETUP: rx_enable=1 for SETTLE_CYCLES; on its last cycle capture bus_in->host_rx_data, rx_error->host_rx_error, set host_rx_valid.
//   RX_STROBE: rx_read=1 for STROBE_CYCLES. RX_RECOVER: RECOVER_CYCLES, then IDLE.
//   rx_enable stays 1 in IDLE while last_driver=RX.
//  host_rx_valid clears on valid&ready. A new capture is impossible while valid=1, so there is no overwrite.
//  Inputs changing mid-sequence (tx_full, rx_active, rx_data_available) are ignored until next IDLE.
//  Reset mid-sequence: strobes and enables drop at the next edge; sequence abandoned; captured word discarded.
//  Latency, IDLE to tx_load rise (same driver): 1 + SETTLE_CYCLES.
//  Timers: $clog2(max param + 1) bits, load param-1, count down to 0.
// CONFIGURATION
//  COAX_BUS_SCHED_ERR_COUNT_EN defined: rx_err_count increments (saturating at 255) on each capture with rx_error=1; cleared by reset.
//  Undefined: rx_err_count tied to 8'd0, no counter logic.
// STRUCTURE
//  Package coax_bus_pkg: WORD_W=10, state enum, driver enum {NONE,TX,RX}.
//  Sub-module coax_strobe_timer: loadable down-counter with done flag; one instance shared by all timed states.
// TESTING
//  Reset, host_tx_data=10'h2A5 valid -> ready pulse; TURN 2 cycles; bus_oe; tx_load high 3 cycles after 2 settle; bus_out=2A5.
//  rx_data_available=1, bus_in=10'h155 -> rx_enable, capture, rx_read 3 cycles; host_rx_data=155, valid=1.
//  Both pending continuously, host always ready -> grant order RX,RX,RX,RX,TX,RX...; turnaround on each driver change.
//  tx_full=1 or rx_active=1 with TX pending -> no tx_load; grant 1 cycle after both drop (same driver).
//  host_rx_ready=0 with valid=1, rx_data_available=1 -> no rx_read until ready.
//  rx_error=1 on 3 words (macro on) -> rx_err_count=3; host_rx_error=1; reset mid TX_STROBE -> tx_load 0 next edge.

Source files
------------

// File: rtl/coax_bus_pkg.sv
// Shared types and helpers for the coax bus scheduler.
package coax_bus_pkg;

    localparam int WORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_TX_SETUP,
        ST_TX_STROBE,
        ST_TX_RECOVER,
        ST_RX_SETUP,
        ST_RX_STROBE,
        ST_RX_RECOVER
    } state_e;

    typedef enum logic [1:0] {
        DRV_NONE,
        DRV_TX,
        DRV_RX
    } driver_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coax_strobe_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module coax_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/coax_bus_sched.sv
// Arbitrates the shared coax data bus between the TX load path and RX read path.
// Optional error counter enabled by COAX_BUS_SCHED_ERR_COUNT_EN.
//
// state         | meaning
// IDLE          | arbitrate; previous driver keeps its enable asserted
// TURN          | bus fully released before a driver change
// TX_SETUP      | bus_oe high, word settling ahead of tx_load
// TX_STROBE     | tx_load high
// TX_RECOVER    | bus held while tx_full catches up with the strobe
// RX_SETUP      | rx_enable high; host register captures on last cycle
// RX_STROBE     | rx_read high
// RX_RECOVER    | wait for rx_data_available to reflect the read
module coax_bus_sched
    import coax_bus_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int STROBE_CYCLES  = 3,
    parameter int RECOVER_CYCLES = 4,
    parameter int TURN_CYCLES    = 2,
    parameter int MAX_RX_BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] host_tx_data,
    input  logic              host_tx_valid,
    output logic              host_tx_ready,
    output logic [WORD_W-1:0] host_rx_data,
    output logic              host_rx_error,
    output logic              host_rx_valid,
    input  logic              host_rx_ready,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [WORD_W-1:0] bus_in,
    output logic              rx_enable,
    output logic              tx_load,
    input  logic              tx_full,
    input  logic              rx_active,
    input  logic              rx_error,
    input  logic              rx_data_available,
    output logic              rx_read,
    output logic [7:0]        rx_err_count
);

    localparam int TMR_MAX = max_of(max_of(SETTLE_CYCLES, STROBE_CYCLES),
                                    max_of(RECOVER_CYCLES, TURN_CYCLES));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BURST_W = $clog2(MAX_RX_BURST + 1);

    localparam logic [TMR_W-1:0]   SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   STROBE_LD  = TMR_W'(STROBE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   RECOVER_LD = TMR_W'(RECOVER_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TURN_LD    = TMR_W'(TURN_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_RX_BURST);

    state_e              state_q, state_d;
    driver_e             last_q, last_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [WORD_W-1:0]   bus_out_q, bus_out_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_err_q, rx_err_d;
    logic                rx_valid_q, rx_valid_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_done;
    logic                rx_cand, tx_cand, grant_tx, grant_rx, capture;

    coax_strobe_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Grants are suppressed under reset so host_tx_ready cannot pulse then.
    always_comb begin
        rx_cand  = rx_data_available & ~rx_valid_q;
        tx_cand  = host_tx_valid & ~tx_full & ~rx_active;
        grant_tx = 1'b0;
        grant_rx = 1'b0;
        if (state_q == ST_IDLE && !reset) begin
            if (tx_cand && (!rx_cand || burst_q == BURST_MAX)) begin
                grant_tx = 1'b1;
            end else if (rx_cand) begin
                grant_rx = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        burst_d   = burst_q;
        bus_out_d = bus_out_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        capture   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_cand) begin
                    burst_d = '0;
                end
                if (grant_tx) begin
                    burst_d   = '0;
                    bus_out_d = host_tx_data;
                    last_d    = DRV_TX;
                    tmr_load  = 1'b1;
                    if (last_q != DRV_TX) begin
                        state_d = ST_TURN;
                        tmr_val = TURN_LD;
                    end else begin
                        state_d = ST_TX_SETUP;
                        tmr_val = SETTLE_LD;
                    end
                end else if (grant_rx) begin
                    if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                    last_d   = DRV_RX;
                    tmr_load = 1'b1;
                    if (last_q != DRV_RX) begin
                        state_d = ST_TURN;
                        tmr_val = TURN_LD;
                    end else begin
                        state_d = ST_RX_SETUP;
                        tmr_val = SETTLE_LD;
                    end
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                    if (last_q == DRV_TX) begin
                        state_d = ST_TX_SETUP;
                    end else begin
                        state_d = ST_RX_SETUP;
                    end
                end
            end
            ST_TX_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_TX_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_TX_STROBE: begin
                if (tmr_done) begin
                    state_d  = ST_TX_RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = RECOVER_LD;
                end
            end
            ST_RX_SETUP: begin
                if (tmr_done) begin
                    capture  = 1'b1;
                    state_d  = ST_RX_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_RX_STROBE: begin
                if (tmr_done) begin
                    state_d  = ST_RX_RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = RECOVER_LD;
                end
            end
            ST_TX_RECOVER, ST_RX_RECOVER: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture cannot coincide with a held word: RX is only granted while empty.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;
        if (capture) begin
            rx_data_d  = bus_in;
            rx_err_d   = rx_error;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && host_rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= DRV_NONE;
            burst_q    <= '0;
            bus_out_q  <= '0;
            rx_data_q  <= '0;
            rx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            bus_out_q  <= bus_out_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign host_tx_ready = grant_tx;
    assign bus_out       = bus_out_q;
    assign host_rx_data  = rx_data_q;
    assign host_rx_error = rx_err_q;
    assign host_rx_valid = rx_valid_q;
    assign tx_load       = (state_q == ST_TX_STROBE);
    assign rx_read       = (state_q == ST_RX_STROBE);
    assign bus_oe        = (state_q inside {ST_TX_SETUP, ST_TX_STROBE, ST_TX_RECOVER}) ||
                           (state_q == ST_IDLE && last_q == DRV_TX);
    assign rx_enable     = (state_q inside {ST_RX_SETUP, ST_RX_STROBE, ST_RX_RECOVER}) ||
                           (state_q == ST_IDLE && last_q == DRV_RX);

`ifdef COAX_BUS_SCHED_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (capture && rx_error && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign rx_err_count = err_cnt_q;
`else
    assign rx_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_coax_bus_sched.sv
// Bench for coax_bus_sched: directed scenarios plus random traffic against a
// schedule-based reference model.
module tb_coax_bus_sched;

    localparam int SETTLE  = 2;
    localparam int STROBE  = 3;
    localparam int RECOVER = 4;
    localparam int TURN    = 2;
    localparam int MAXB    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [9:0] host_rx_data;
    logic       host_rx_error;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic [9:0] bus_out;
    logic       bus_oe;
    logic [9:0] bus_in;
    logic       rx_enable;
    logic       tx_load;
    logic       tx_full;
    logic       rx_active;
    logic       rx_error;
    logic       rx_data_available;
    logic       rx_read;
    logic [7:0] rx_err_count;

    always #5 clk = ~clk;

    coax_bus_sched #(
        .SETTLE_CYCLES (SETTLE),
        .STROBE_CYCLES (STROBE),
        .RECOVER_CYCLES(RECOVER),
        .TURN_CYCLES   (TURN),
        .MAX_RX_BURST  (MAXB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_tx_data     (host_tx_data),
        .host_tx_valid    (host_tx_valid),
        .host_tx_ready    (host_tx_ready),
        .host_rx_data     (host_rx_data),
        .host_rx_error    (host_rx_error),
        .host_rx_valid    (host_rx_valid),
        .host_rx_ready    (host_rx_ready),
        .bus_out          (bus_out),
        .bus_oe           (bus_oe),
        .bus_in           (bus_in),
        .rx_enable        (rx_enable),
        .tx_load          (tx_load),
        .tx_full          (tx_full),
        .rx_active        (rx_active),
        .rx_error         (rx_error),
        .rx_data_available(rx_data_available),
        .rx_read          (rx_read),
        .rx_err_count     (rx_err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each grant expands into a per-cycle table of expected strobes.
    typedef struct {
        bit oe;
        bit en;
        bit ld;
        bit rd;
        bit cap;
    } step_t;

    step_t      sched[$];
    int         m_last;      // 0 none, 1 tx, 2 rx
    int         m_burst;
    logic [9:0] m_bus_out;
    logic [9:0] m_rx_data;
    logic       m_rx_err;
    logic       m_rx_valid;
    int         m_errs;

    task automatic model_reset();
        sched.delete();
        m_last     = 0;
        m_burst    = 0;
        m_bus_out  = '0;
        m_rx_data  = '0;
        m_rx_err   = 1'b0;
        m_rx_valid = 1'b0;
        m_errs     = 0;
    endtask

    task automatic plan(input bit is_tx, input bit turn);
        step_t s;
        if (turn) begin
            for (int i = 0; i < TURN; i++) begin
                s = '{oe: 1'b0, en: 1'b0, ld: 1'b0, rd: 1'b0, cap: 1'b0};
                sched.push_back(s);
            end
        end
        for (int i = 0; i < SETTLE; i++) begin
            s = '{oe: is_tx, en: !is_tx, ld: 1'b0, rd: 1'b0, cap: (!is_tx && i == SETTLE - 1)};
            sched.push_back(s);
        end
        for (int i = 0; i < STROBE; i++) begin
            s = '{oe: is_tx, en: !is_tx, ld: is_tx, rd: !is_tx, cap: 1'b0};
            sched.push_back(s);
        end
        for (int i = 0; i < RECOVER; i++) begin
            s = '{oe: is_tx, en: !is_tx, ld: 1'b0, rd: 1'b0, cap: 1'b0};
            sched.push_back(s);
        end
    endtask

    always @(negedge clk) begin : model
        step_t s;
        bit idle, rc, tc, g_tx, g_rx, cap;
        bit e_oe, e_en, e_ld, e_rd, e_rdy;
        if (reset === 1'b1) begin
            model_reset();
        end else begin
            g_tx = 1'b0;
            g_rx = 1'b0;
            cap  = 1'b0;
            rc   = 1'b0;
            idle = (sched.size() == 0);
            if (idle) begin
                rc    = rx_data_available && !m_rx_valid;
                tc    = host_tx_valid && !tx_full && !rx_active;
                g_tx  = tc && (!rc || m_burst == MAXB);
                g_rx  = rc && !g_tx;
                e_oe  = (m_last == 1);
                e_en  = (m_last == 2);
                e_ld  = 1'b0;
                e_rd  = 1'b0;
                e_rdy = g_tx;
            end else begin
                s     = sched.pop_front();
                e_oe  = s.oe;
                e_en  = s.en;
                e_ld  = s.ld;
                e_rd  = s.rd;
                e_rdy = 1'b0;
                cap   = s.cap;
            end
            chk("m_tx_ready", host_tx_ready, e_rdy);
            chk("m_bus_oe", bus_oe, e_oe);
            chk("m_rx_enable", rx_enable, e_en);
            chk("m_tx_load", tx_load, e_ld);
            chk("m_rx_read", rx_read, e_rd);
            chk("m_bus_out", bus_out, m_bus_out);
            chk("m_rx_valid", host_rx_valid, m_rx_valid);
            chk("m_rx_data", host_rx_data, m_rx_data);
            chk("m_rx_error", host_rx_error, m_rx_err);
            chk("m_err_count", rx_err_count, m_errs);
            chk("m_oe_en_excl", bus_oe & rx_enable, 1'b0);

            if (g_tx) begin
                plan(1'b1, m_last != 1);
                m_last    = 1;
                m_burst   = 0;
                m_bus_out = host_tx_data;
            end else if (g_rx) begin
                plan(1'b0, m_last != 2);
                m_last = 2;
                if (m_burst < MAXB) m_burst++;
            end else if (idle && !rc) begin
                m_burst = 0;
            end

            if (cap) begin
                m_rx_data  = bus_in;
                m_rx_err   = rx_error;
                m_rx_valid = 1'b1;
`ifdef COAX_BUS_SCHED_ERR_COUNT_EN
                if (rx_error && m_errs < 255) m_errs++;
`endif
            end else if (m_rx_valid && host_rx_ready) begin
                m_rx_valid = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return tx_load;
            1:       return rx_read;
            2:       return host_tx_ready;
            default: return host_rx_valid;
        endcase
    endfunction

    // Counts negedges until the selected signal reaches lvl; -1 on timeout.
    task automatic wait_lvl(input int which, input logic lvl, input int budget,
                            input string tag, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n++;
            if (sel_sig(which) === lvl) return;
        end
        chk({tag, "_timeout"}, sel_sig(which), lvl);
        n = -1;
    endtask

    localparam int S_LD = 0, S_RD = 1, S_RDY = 2;

    int exp_errs;
    int n, cnt;
    int order[$];
    logic p_ld, p_rd;

    initial begin
        reset = 1'b1; host_tx_data = '0; host_tx_valid = 1'b0; host_rx_ready = 1'b0;
        bus_in = '0; tx_full = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
        rx_data_available = 1'b0;
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bus_oe", bus_oe, 1'b0);
        chk("rst_rx_enable", rx_enable, 1'b0);
        chk("rst_tx_load", tx_load, 1'b0);
        chk("rst_rx_read", rx_read, 1'b0);
        chk("rst_rx_valid", host_rx_valid, 1'b0);
        chk("rst_bus_out", bus_out, 10'h000);
        chk("rst_err_count", rx_err_count, 8'd0);

        // First TX after reset: turnaround then settle then strobe
        cyc(1);
        host_tx_data = 10'h2A5; host_tx_valid = 1'b1;
        wait_lvl(S_RDY, 1'b1, 20, "tx_ready", n);
        chk("tx_ready_first_cycle", n, 1);
        cyc(1);
        host_tx_valid = 1'b0;
        wait_lvl(S_LD, 1'b1, 30, "tx_load_rise", n);
        chk("tx_latency_turn", n, TURN + SETTLE + 1);
        chk("tx_bus_out", bus_out, 10'h2A5);
        chk("tx_bus_oe", bus_oe, 1'b1);
        wait_lvl(S_LD, 1'b0, 30, "tx_load_fall", n);
        chk("tx_load_width", n, STROBE);
        cyc(6);

        // TX blocked by tx_full, then by rx_active
        host_tx_data = 10'h0F0; host_tx_valid = 1'b1; tx_full = 1'b1;
        cnt = 0;
        repeat (15) begin @(negedge clk); if (tx_load || host_tx_ready) cnt++; end
        chk("blocked_tx_full", cnt, 0);
        cyc(1);
        tx_full = 1'b0; rx_active = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (tx_load || host_tx_ready) cnt++; end
        chk("blocked_rx_active", cnt, 0);
        cyc(1);
        rx_active = 1'b0;
        @(negedge clk);
        chk("tx_grant_after_block", host_tx_ready, 1'b1);
        cyc(1);
        host_tx_valid = 1'b0;
        wait_lvl(S_LD, 1'b1, 30, "tx_load_same", n);
        chk("tx_latency_same", n, SETTLE + 1);
        chk("tx_bus_out2", bus_out, 10'h0F0);
        cyc(8);

        // RX capture, then hold while host not ready
        host_rx_ready = 1'b0; bus_in = 10'h155; rx_data_available = 1'b1;
        wait_lvl(S_RD, 1'b1, 40, "rx_read_rise", n);
        chk("rx_read_latency", n, 1 + TURN + SETTLE + 1);
        chk("rx_valid_set", host_rx_valid, 1'b1);
        chk("rx_data_155", host_rx_data, 10'h155);
        wait_lvl(S_RD, 1'b0, 30, "rx_read_fall", n);
        chk("rx_read_width", n, STROBE);
        cnt = 0;
        repeat (20) begin @(negedge clk); if (rx_read) cnt++; end
        chk("rx_hold_no_read", cnt, 0);
        chk("rx_hold_data", host_rx_data, 10'h155);
        cyc(1);
        host_rx_ready = 1'b1; bus_in = 10'h0AA;
        wait_lvl(S_RD, 1'b1, 30, "rx_read_after_ready", n);
        chk("rx_data_second", host_rx_data, 10'h0AA);
        cyc(1);
        rx_data_available = 1'b0;
        cyc(10);

        // Fairness with both sides pending continuously
        reset = 1'b1; cyc(2); reset = 1'b0;
        host_tx_valid = 1'b1; rx_data_available = 1'b1; host_rx_ready = 1'b1;
        p_ld = 1'b0; p_rd = 1'b0;
        for (int k = 0; k < 400 && order.size() < 10; k++) begin
            @(negedge clk);
            if (tx_load && !p_ld) order.push_back(1);
            if (rx_read && !p_rd) order.push_back(0);
            p_ld = tx_load; p_rd = rx_read;
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("grant_order_%0d", i), (i < order.size()) ? order[i] : 2,
                (i % (MAXB + 1) == MAXB) ? 1 : 0);
        end
        cyc(1);
        host_tx_valid = 1'b0; rx_data_available = 1'b0;
        cyc(15);

        // Three error words
        reset = 1'b1; cyc(2); reset = 1'b0;
        rx_error = 1'b1; rx_data_available = 1'b1; host_rx_ready = 1'b1; bus_in = 10'h3FF;
        cnt = 0; p_rd = 1'b0;
        for (int k = 0; k < 200 && cnt < 3; k++) begin
            @(negedge clk);
            if (rx_read && !p_rd) cnt++;
            p_rd = rx_read;
        end
        chk("err_words_seen", cnt, 3);
        chk("err_host_flag", host_rx_error, 1'b1);
        cyc(1);
        rx_data_available = 1'b0;
        cyc(12);
`ifdef COAX_BUS_SCHED_ERR_COUNT_EN
        exp_errs = 3;
`else
        exp_errs = 0;
`endif
        chk("err_count", rx_err_count, exp_errs);
        rx_error = 1'b0;

        // Reset during TX strobe
        host_tx_data = 10'h1C3; host_tx_valid = 1'b1;
        wait_lvl(S_LD, 1'b1, 40, "mid_tx_load", n);
        cyc(1);
        reset = 1'b1; host_tx_valid = 1'b0;
        cyc(1);
        chk("mid_rst_tx_load", tx_load, 1'b0);
        chk("mid_rst_bus_oe", bus_oe, 1'b0);
        chk("mid_rst_bus_out", bus_out, 10'h000);
        cyc(1);
        reset = 1'b0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            reset             = ($urandom_range(0, 399) == 0);
            host_tx_valid     = ($urandom_range(0, 2) != 0);
            host_tx_data      = 10'($urandom);
            tx_full           = ($urandom_range(0, 3) == 0);
            rx_active         = ($urandom_range(0, 3) == 0);
            rx_error          = 1'($urandom);
            rx_data_available = 1'($urandom);
            host_rx_ready     = 1'($urandom);
            bus_in            = 10'($urandom);
        end
        cyc(1);
        reset = 1'b0; host_tx_valid = 1'b0; rx_data_available = 1'b0;
        tx_full = 1'b0; rx_active = 1'b0; host_rx_ready = 1'b1;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
